// File: rtl/vc_intr_pkg.sv
// ---------------------------------------------------------------------------
// vc_intr_pkg
// Shared definitions for the prioritised interrupt controller: word register
// indices of the CPU-facing bus, the largest supported source count and the
// width of a source id (id 0 means "no source", ids 1..15 name sources 0..14).
// ---------------------------------------------------------------------------
package vc_intr_pkg;

    localparam int MAX_NSRC = 15;
    localparam int ID_W     = 4;

    typedef logic [ID_W-1:0] intr_id_t;

    localparam logic [3:0] REG_PENDING   = 4'd0;
    localparam logic [3:0] REG_ENABLE    = 4'd1;
    localparam logic [3:0] REG_MODE      = 4'd2;
    localparam logic [3:0] REG_CLAIM     = 4'd3;
    localparam logic [3:0] REG_COMPLETE  = 4'd4;
    localparam logic [3:0] REG_THRESHOLD = 4'd5;
    localparam logic [3:0] REG_PRIO0     = 4'd8;
    localparam logic [3:0] REG_PRIO1     = 4'd9;
    localparam logic [3:0] REG_PRIO2     = 4'd10;
    localparam logic [3:0] REG_PRIO3     = 4'd11;

    // Word index of the PRIO register that holds source i (four per word).
    function automatic logic [3:0] prio_word(input int i);
        return REG_PRIO0 + 4'(i / 4);
    endfunction

endpackage

// File: rtl/intr_arb.sv
// ---------------------------------------------------------------------------
// intr_arb
// Purely combinational arbiter: picks the eligible source with the highest
// priority, lowest index on ties.
//   eligible  : one bit per source, already qualified by the caller
//   prio_flat : priority of source i at bits [i*PW +: PW]
//   win_id    : winner index + 1 (0 when nothing is eligible)
//   win_valid : at least one source eligible
// ---------------------------------------------------------------------------
module intr_arb
    import vc_intr_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int PW   = 2
) (
    input  logic [NSRC-1:0]    eligible,
    input  logic [NSRC*PW-1:0] prio_flat,
    output intr_id_t           win_id,
    output logic               win_valid
);

    logic [PW-1:0] best_prio;

    // Scan from index 0 upward; only a strictly higher priority displaces
    // the current pick, which is what gives the lowest index on ties.
    always_comb begin
        win_valid = 1'b0;
        win_id    = '0;
        best_prio = '0;
        for (int i = 0; i < NSRC; i++) begin
            if (eligible[i] && (!win_valid || (prio_flat[i*PW +: PW] > best_prio))) begin
                win_valid = 1'b1;
                win_id    = ID_W'(i + 1);
                best_prio = prio_flat[i*PW +: PW];
            end
        end
    end

endmodule

// File: rtl/prio_intr.sv
// ---------------------------------------------------------------------------
// prio_intr
// Prioritised interrupt controller with claim/complete handshake.
//   clk, reset   : single clock, synchronous active-high reset
//   src          : raw request lines, registered once on entry
//   interrupt    : registered request to the CPU
//   io_addr      : word register index
//   io_write     : write strobe (io_wdata)
//   io_read      : read strobe; a CLAIM read has side effects
//   io_rdata     : combinational read data for io_addr
// Register words: 0 PENDING (W1C), 1 ENABLE, 2 MODE, 3 CLAIM, 4 COMPLETE,
// 5 THRESHOLD, 8..11 PRIO (four 4-bit slots per word).
// Build option: define PRIO_INTR_EDGE_EN to get the MODE register and
// per-source rising-edge capture; otherwise every source is level-sensitive.
// ---------------------------------------------------------------------------
module prio_intr
    import vc_intr_pkg::*;
#(
    parameter int NSRC = 8,
    parameter int PW   = 2
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NSRC-1:0] src,
    output logic            interrupt,
    input  logic [3:0]      io_addr,
    input  logic            io_write,
    input  logic            io_read,
    input  logic [15:0]     io_wdata,
    output logic [15:0]     io_rdata
);

    logic [NSRC-1:0] src_q, src_d;
    logic [NSRC-1:0] pending_q, pending_d;
    logic [NSRC-1:0] enable_q, enable_d;
    logic [NSRC-1:0] in_service_q, in_service_d;
    logic [PW-1:0]   threshold_q, threshold_d;
    logic [PW-1:0]   prio_q [NSRC];
    logic [PW-1:0]   prio_d [NSRC];
    logic            interrupt_q, interrupt_d;

    logic [NSRC-1:0]    eligible;
    logic [NSRC*PW-1:0] prio_flat;
    intr_id_t           win_id;
    logic               win_valid;
    logic               claim_fire;
    logic [NSRC-1:0]    claim_set;
    logic [NSRC-1:0]    complete_clr;
    logic [15:0]        prio_rd [4];
    logic [15:0]        mode_rd;

`ifdef PRIO_INTR_EDGE_EN
    logic [NSRC-1:0] src_prev_q, src_prev_d;
    logic [NSRC-1:0] mode_q, mode_d;
    logic [NSRC-1:0] rise;
    logic [NSRC-1:0] w1c;
    logic [NSRC-1:0] pend_clr;
`endif

    // A claim only has side effects when it actually hands out a source and
    // no write shares the cycle.
    assign claim_fire = io_read && !io_write && (io_addr == REG_CLAIM) && win_valid;

    generate
        for (genvar gi = 0; gi < NSRC; gi++) begin : g_src
            localparam logic [3:0] PWORD = prio_word(gi);

            assign eligible[gi] = pending_q[gi] && enable_q[gi] && !in_service_q[gi]
                                  && (prio_q[gi] > threshold_q);
            assign prio_flat[gi*PW +: PW] = prio_q[gi];
            assign claim_set[gi] = claim_fire && (win_id == ID_W'(gi + 1));
            assign complete_clr[gi] = io_write && (io_addr == REG_COMPLETE)
                                      && (io_wdata == 16'(gi + 1));
            assign prio_d[gi] = (io_write && (io_addr == PWORD))
                                ? io_wdata[4*(gi%4) +: PW] : prio_q[gi];
        end
    endgenerate

    intr_arb #(
        .NSRC (NSRC),
        .PW   (PW)
    ) u_arb (
        .eligible  (eligible),
        .prio_flat (prio_flat),
        .win_id    (win_id),
        .win_valid (win_valid)
    );

    always_comb begin
        src_d        = src;
        enable_d     = (io_write && (io_addr == REG_ENABLE)) ? io_wdata[NSRC-1:0] : enable_q;
        threshold_d  = (io_write && (io_addr == REG_THRESHOLD)) ? io_wdata[PW-1:0] : threshold_q;
        in_service_d = (in_service_q | claim_set) & ~complete_clr;
        interrupt_d  = |eligible;
`ifdef PRIO_INTR_EDGE_EN
        src_prev_d = src_q;
        mode_d     = (io_write && (io_addr == REG_MODE)) ? io_wdata[NSRC-1:0] : mode_q;
        rise       = src_q & ~src_prev_q;
        w1c        = (io_write && (io_addr == REG_PENDING)) ? io_wdata[NSRC-1:0] : '0;
        pend_clr   = w1c | claim_set;
        // Edge sources: a new edge wins over a same-cycle clear.
        // Level sources simply track the registered line.
        pending_d  = (mode_q & ((pending_q & ~pend_clr) | rise)) | (~mode_q & src_q);
        mode_rd    = 16'(mode_q);
`else
        pending_d  = src_q;
        mode_rd    = '0;
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            src_q        <= '0;
            pending_q    <= '0;
            enable_q     <= '0;
            in_service_q <= '0;
            threshold_q  <= '0;
            interrupt_q  <= 1'b0;
            for (int i = 0; i < NSRC; i++) prio_q[i] <= '0;
        end else begin
            src_q        <= src_d;
            pending_q    <= pending_d;
            enable_q     <= enable_d;
            in_service_q <= in_service_d;
            threshold_q  <= threshold_d;
            interrupt_q  <= interrupt_d;
            for (int i = 0; i < NSRC; i++) prio_q[i] <= prio_d[i];
        end
    end

`ifdef PRIO_INTR_EDGE_EN
    always_ff @(posedge clk) begin
        if (reset) begin
            src_prev_q <= '0;
            mode_q     <= '0;
        end else begin
            src_prev_q <= src_prev_d;
            mode_q     <= mode_d;
        end
    end
`endif

    assign interrupt = interrupt_q;

    // Pack the priority slots back into their bus words.
    always_comb begin
        for (int k = 0; k < 4; k++) prio_rd[k] = '0;
        for (int i = 0; i < NSRC; i++) prio_rd[i/4][4*(i%4) +: PW] = prio_q[i];
    end

    always_comb begin
        io_rdata = '0;
        case (io_addr)
            REG_PENDING:   io_rdata = 16'(pending_q);
            REG_ENABLE:    io_rdata = 16'(enable_q);
            REG_MODE:      io_rdata = mode_rd;
            REG_CLAIM:     io_rdata = 16'(win_id);
            REG_THRESHOLD: io_rdata = 16'(threshold_q);
            REG_PRIO0:     io_rdata = prio_rd[0];
            REG_PRIO1:     io_rdata = prio_rd[1];
            REG_PRIO2:     io_rdata = prio_rd[2];
            REG_PRIO3:     io_rdata = prio_rd[3];
            default:       io_rdata = '0;
        endcase
    end

endmodule

// File: tb/tb_prio_intr.sv
// ---------------------------------------------------------------------------
// tb_prio_intr
// Directed scenarios followed by random bus/source traffic, every cycle
// compared against a behavioural model of the controller.
// ---------------------------------------------------------------------------
module tb_prio_intr;

    localparam int NSRC = 8;
    localparam int PW   = 2;

    logic            clk;
    logic            reset;
    logic [NSRC-1:0] src;
    logic            interrupt;
    logic [3:0]      io_addr;
    logic            io_write;
    logic            io_read;
    logic [15:0]     io_wdata;
    logic [15:0]     io_rdata;

    int n_vec;
    int n_err;

    prio_intr #(
        .NSRC (NSRC),
        .PW   (PW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .src       (src),
        .interrupt (interrupt),
        .io_addr   (io_addr),
        .io_write  (io_write),
        .io_read   (io_read),
        .io_wdata  (io_wdata),
        .io_rdata  (io_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- behavioural model ----------------
    bit m_line [NSRC];   // input line as seen after the entry register
    bit m_last [NSRC];   // line one cycle earlier (edge reference)
    bit m_pend [NSRC];
    bit m_en   [NSRC];
    bit m_mode [NSRC];
    bit m_busy [NSRC];
    int m_prio [NSRC];
    int m_thr;
    bit m_irq;

    function automatic void model_reset();
        for (int i = 0; i < NSRC; i++) begin
            m_line[i] = 0; m_last[i] = 0; m_pend[i] = 0; m_en[i] = 0;
            m_mode[i] = 0; m_busy[i] = 0; m_prio[i] = 0;
        end
        m_thr = 0;
        m_irq = 0;
    endfunction

    function automatic bit can_fire(input int i);
        return m_pend[i] && m_en[i] && !m_busy[i] && (m_prio[i] > m_thr);
    endfunction

    // Highest priority first, then lowest index among those at that level.
    function automatic int model_winner();
        int top = -1;
        for (int i = 0; i < NSRC; i++)
            if (can_fire(i) && m_prio[i] > top) top = m_prio[i];
        if (top < 0) return 0;
        for (int i = 0; i < NSRC; i++)
            if (can_fire(i) && m_prio[i] == top) return i + 1;
        return 0;
    endfunction

    function automatic int model_read(input int a);
        int v = 0;
        if (a == 0) begin
            for (int i = 0; i < NSRC; i++) if (m_pend[i]) v += (1 << i);
        end else if (a == 1) begin
            for (int i = 0; i < NSRC; i++) if (m_en[i]) v += (1 << i);
        end else if (a == 2) begin
`ifdef PRIO_INTR_EDGE_EN
            for (int i = 0; i < NSRC; i++) if (m_mode[i]) v += (1 << i);
`endif
        end else if (a == 3) begin
            v = model_winner();
        end else if (a == 5) begin
            v = m_thr;
        end else if (a >= 8 && a <= 11) begin
            for (int i = 0; i < NSRC; i++)
                if (i / 4 == a - 8) v += m_prio[i] << (4 * (i % 4));
        end
        return v;
    endfunction

    function automatic void model_clock(input logic [NSRC-1:0] s, input int a,
                                        input bit w, input bit r, input int d);
        int  win;
        bit  any;
        int  pmask;
        if (reset) begin
            model_reset();
            return;
        end
        win   = model_winner();
        any   = (win != 0);
        pmask = (1 << PW) - 1;
        for (int i = 0; i < NSRC; i++) begin
            bit edge_seen  = m_line[i] && !m_last[i];
            bit claimed    = r && !w && a == 3 && win == i + 1;
            bit w1c_hit    = w && a == 0 && d[i];
            if (m_mode[i]) begin
                if (edge_seen)              m_pend[i] = 1;
                else if (claimed || w1c_hit) m_pend[i] = 0;
            end else begin
                m_pend[i] = m_line[i];
            end
            if (claimed) m_busy[i] = 1;
            if (w && a == 4 && d == i + 1) m_busy[i] = 0;
            if (w && a == 1) m_en[i] = d[i];
`ifdef PRIO_INTR_EDGE_EN
            if (w && a == 2) m_mode[i] = d[i];
`endif
            if (w && a == 8 + i / 4) m_prio[i] = (d >> (4 * (i % 4))) & pmask;
            m_last[i] = m_line[i];
            m_line[i] = s[i];
        end
        if (w && a == 5) m_thr = d & pmask;
        m_irq = any;
    endfunction

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // One bus cycle: drive, check against model (and an optional fixed
    // expectation), then clock the model alongside the DUT.
    task automatic cyc(input logic [NSRC-1:0] s, input int a, input bit w, input bit r,
                       input int d, input int exp_rd, input int exp_irq, input string tag);
        src      = s;
        io_addr  = 4'(a);
        io_write = w;
        io_read  = r;
        io_wdata = 16'(d);
        #2;
        chk({tag, ".rdata"}, io_rdata, 16'(model_read(a)));
        chk({tag, ".irq"}, {15'd0, interrupt}, {15'd0, m_irq});
        if (exp_rd >= 0) chk({tag, ".rdata_fixed"}, io_rdata, 16'(exp_rd));
        if (exp_irq >= 0) chk({tag, ".irq_fixed"}, {15'd0, interrupt}, 16'(exp_irq));
        $display("cyc %-10s src=%h addr=%0d w=%0d r=%0d wd=%h rd=%h irq=%0d",
                 tag, s, a, w, r, d[15:0], io_rdata, interrupt);
        @(posedge clk);
        model_clock(s, a, w, r, d);
        #1;
    endtask

    task automatic idle(input logic [NSRC-1:0] s, input int n, input string tag);
        for (int k = 0; k < n; k++) cyc(s, 0, 0, 0, 0, -1, -1, tag);
    endtask

    task automatic wr(input int a, input int d, input string tag);
        cyc(src, a, 1, 0, d, -1, -1, tag);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        cyc('0, 0, 0, 0, 0, -1, -1, "reset");
        cyc('0, 0, 0, 0, 0, -1, -1, "reset");
        reset = 1'b0;
    endtask

    initial begin
        n_vec = 0; n_err = 0;
        reset = 1'b1; src = '0; io_addr = '0; io_write = 0; io_read = 0; io_wdata = '0;
        repeat (2) @(posedge clk);
        #1;
        model_reset();
        reset = 1'b0;

        // reset state: every word reads zero, no interrupt
        for (int a = 0; a < 16; a++) cyc('0, a, 0, 0, 0, 0, 0, "rst_rd");

        // single level source, latency and first claim
        wr(1, 16'h0004, "s30_en");
        wr(8, 16'h0100, "s30_prio");
        cyc(8'h04, 0, 0, 0, 0, -1, 0, "s30_rise");
        cyc(8'h04, 0, 0, 0, 0, -1, 0, "s30_n1");
        cyc(8'h04, 0, 0, 0, 0, -1, 0, "s30_n2");
        cyc(8'h04, 3, 0, 1, 0, 3, 1, "s30_claim");
        cyc(8'h04, 3, 0, 0, 0, 0, 1, "s30_post");
        cyc(8'h04, 3, 0, 0, 0, 0, 0, "s30_low");
        do_reset();

        // priority ordering and complete
        wr(1, 16'h0022, "s31_en");
        wr(8, 16'h0020, "s31_p1");
        wr(9, 16'h0030, "s31_p5");
        idle(8'h22, 3, "s31_wait");
        cyc(8'h22, 3, 0, 1, 0, 6, 1, "s31_claim6");
        idle(8'h02, 3, "s31_drop5");
        cyc(8'h02, 4, 1, 0, 6, -1, -1, "s31_cmpl6");
        cyc(8'h02, 3, 0, 1, 0, 2, -1, "s31_claim2");
        do_reset();

        // equal priorities resolve to lowest index
        wr(1, 16'h0009, "s32_en");
        wr(8, 16'h2002, "s32_prio");
        idle(8'h09, 3, "s32_wait");
        cyc(8'h09, 3, 0, 1, 0, 1, 1, "s32_claim1");
        cyc(8'h09, 3, 0, 1, 0, 4, -1, "s32_claim4");
        do_reset();

`ifdef PRIO_INTR_EDGE_EN
        // edge source re-pends while in service, fires after complete
        wr(2, 16'h0010, "s33_mode");
        wr(1, 16'h0010, "s33_en");
        wr(9, 16'h0001, "s33_prio");
        cyc(8'h10, 0, 0, 0, 0, -1, 0, "s33_pulse");
        idle(8'h00, 3, "s33_wait");
        cyc(8'h00, 3, 0, 1, 0, 5, 1, "s33_claim5");
        cyc(8'h10, 0, 0, 0, 0, -1, -1, "s33_pulse2");
        idle(8'h00, 3, "s33_wait2");
        cyc(8'h00, 0, 0, 0, 0, 16'h0010, 0, "s33_pend");
        cyc(8'h00, 4, 1, 0, 5, -1, 0, "s33_cmpl5");
        cyc(8'h00, 0, 0, 0, 0, -1, 0, "s33_c1");
        cyc(8'h00, 3, 0, 0, 0, 5, 1, "s33_c2");
        do_reset();
`endif

        // threshold masking
        wr(8, 16'h0200, "s34_prio");
        wr(1, 16'h0004, "s34_en");
        wr(5, 16'h0002, "s34_thr2");
        idle(8'h04, 3, "s34_wait");
        cyc(8'h04, 3, 0, 0, 0, 0, 0, "s34_masked");
        cyc(8'h04, 5, 1, 0, 1, -1, 0, "s34_thr1");
        cyc(8'h04, 0, 0, 0, 0, -1, 0, "s34_t1");
        cyc(8'h04, 3, 0, 0, 0, 3, 1, "s34_t2");
        do_reset();

        // reset while in service
        wr(8, 16'h1000, "s35_prio");
        wr(1, 16'h0008, "s35_en");
        idle(8'h08, 3, "s35_wait");
        cyc(8'h08, 3, 0, 1, 0, 4, 1, "s35_claim4");
        reset = 1'b1;
        cyc(8'h00, 0, 0, 0, 0, -1, -1, "s35_reset");
        reset = 1'b0;
        for (int a = 0; a < 16; a++) cyc('0, a, 0, 0, 0, 0, 0, "s35_rd");
        cyc(8'h00, 4, 1, 0, 4, -1, -1, "s35_cmpl4");
        wr(8, 16'h1000, "s35_prio2");
        wr(1, 16'h0008, "s35_en2");
        idle(8'h08, 3, "s35_wait2");
        cyc(8'h08, 3, 0, 1, 0, 4, 1, "s35_reclaim");

        // random traffic
        for (int k = 0; k < 600; k++) begin
            logic [NSRC-1:0] s;
            int a, d;
            bit w, r;
            s = NSRC'($urandom);
            a = $urandom_range(0, 15);
            w = ($urandom_range(0, 3) == 0);
            r = ($urandom_range(0, 2) == 0);
            d = (a == 4) ? $urandom_range(0, 10) : int'($urandom_range(0, 16'hffff));
            if ($urandom_range(0, 3) == 0) a = 3;
            reset = ($urandom_range(0, 199) == 0);
            cyc(s, a, w, r, d, -1, -1, "rand");
        end
        reset = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
